// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: sequencer that owns the core clock divider's configuration
// inputs. Each request is applied glitch-safely: switch to bypass, write the
// divider, wait for the new ratio to settle, then re-select the divided clock.
module clock_div_ctrl #(
  parameter int DIV_LOG       = 4,
  parameter int SEL_WAIT      = 2,
  parameter int SETTLE_MARGIN = 4,
  parameter int RST_DIV       = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  input  logic [DIV_LOG-1:0] i_req_div,
  input  logic               i_req_en,
  output logic               o_req_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic [DIV_LOG-1:0] o_div,
  output logic               o_div_we,
  output logic               o_clock_sel,
  output logic [DIV_LOG-1:0] o_cur_div,
  output logic               o_cur_en
);

  // Settle counter holds up to 2^(2^DIV_LOG-1) * 2 + small constant.
  localparam int CNT_W = (1 << DIV_LOG) + 2;
  localparam int BYP_W = $clog2(SEL_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BYPASS,
    S_WRITE,
    S_SETTLE,
    S_SELECT,
    S_DONE
  } state_t;

  state_t             state;
  logic [DIV_LOG-1:0] new_div;
  logic               new_en;
  logic [BYP_W-1:0]   byp_cnt;
  logic [CNT_W-1:0]   settle_cnt;
  logic [CNT_W-1:0]   settle_load;

  // Settle time covers one full period of the old ratio plus one of the new.
  assign settle_load = (CNT_W'(1) << o_cur_div) + (CNT_W'(1) << new_div)
                     + CNT_W'(2 + SETTLE_MARGIN);

  // Single-process FSM; every output is registered on entry to its state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      new_div     <= DIV_LOG'(RST_DIV);
      new_en      <= 1'b0;
      byp_cnt     <= '0;
      settle_cnt  <= '0;
      o_div       <= DIV_LOG'(RST_DIV);
      o_div_we    <= 1'b0;
      o_clock_sel <= 1'b0;
      o_cur_div   <= DIV_LOG'(RST_DIV);
      o_cur_en    <= 1'b0;
      o_done      <= 1'b0;
      o_req_ready <= 1'b1;
      o_busy      <= 1'b0;
    end else begin
      // NOTE: outputs are assigned on the transition into a state so the
      // registered value is visible for exactly the cycles spent in it; the
      // defaults below make the single-cycle pulses drop automatically.
      o_div_we <= 1'b0;
      o_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req_valid && o_req_ready) begin
            new_div     <= i_req_div;
            new_en      <= i_req_en;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
            if (i_req_div == o_cur_div && i_req_en == o_cur_en) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state       <= S_BYPASS;
              o_clock_sel <= 1'b0;
              byp_cnt     <= '0;
            end
          end
        end
        S_BYPASS: begin
          if (byp_cnt == BYP_W'(SEL_WAIT - 1)) begin
            if (new_div != o_cur_div) begin
              state    <= S_WRITE;
              o_div    <= new_div;
              o_div_we <= 1'b1;
            end else begin
              state       <= S_SELECT;
              o_clock_sel <= new_en;
              o_cur_div   <= new_div;
              o_cur_en    <= new_en;
            end
          end else begin
            byp_cnt <= byp_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          // SETTLE then walks load-1 down to 0: exactly 'load' cycles.
          settle_cnt <= settle_load - CNT_W'(1);
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state       <= S_SELECT;
            o_clock_sel <= new_en;
            o_cur_div   <= new_div;
            o_cur_en    <= new_en;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end
        S_SELECT: begin
          state  <= S_DONE;
          o_done <= 1'b1;
        end
        S_DONE: begin
          state       <= S_IDLE;
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed testbench for clock_div_ctrl with hand-computed cycle timings.
// Cycle 0 is the cycle in which a request is presented; cycle k is observed
// 1 time unit after the k-th following rising edge.
module tb_clock_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_req_valid;
  logic [3:0] i_req_div;
  logic       i_req_en;
  logic       o_req_ready, o_busy, o_done, o_div_we, o_clock_sel, o_cur_en;
  logic [3:0] o_div, o_cur_div;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the last run_seq call.
  int   r_we_cyc, r_we_cnt, r_we_max_run, r_sel_rise_cyc, r_done_cyc, r_done_cnt;
  int   r_ready_cyc;
  logic [3:0] r_we_div, r_cur_div_sel;
  logic r_sel_at1, r_busy_at1, r_ready_at1, r_sel_low_seen, r_timeout;

  clock_div_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (i_req_valid),
    .i_req_div   (i_req_div),
    .i_req_en    (i_req_en),
    .o_req_ready (o_req_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_div       (o_div),
    .o_div_we    (o_div_we),
    .o_clock_sel (o_clock_sel),
    .o_cur_div   (o_cur_div),
    .o_cur_en    (o_cur_en)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request in cycle 0 and record event timings until ready returns.
  task automatic run_seq(input logic [3:0] d, input logic e, input int max_cyc);
    int cyc = 0;
    int run = 0;
    logic prev_sel;
    logic [3:0] prev_cur;
    r_we_cyc = -1; r_we_cnt = 0; r_we_max_run = 0; r_sel_rise_cyc = -1;
    r_done_cyc = -1; r_done_cnt = 0; r_ready_cyc = -1; r_we_div = 'x;
    r_cur_div_sel = 'x; r_sel_low_seen = 1'b0; r_timeout = 1'b0;
    prev_sel = o_clock_sel;
    prev_cur = o_cur_div;
    i_req_valid = 1'b1; i_req_div = d; i_req_en = e;
    while (1) begin
      step();
      cyc++;
      if (cyc == 1) begin
        i_req_valid = 1'b0;
        r_sel_at1 = o_clock_sel; r_busy_at1 = o_busy; r_ready_at1 = o_req_ready;
      end
      if (o_div_we) begin
        r_we_cnt++; run++;
        if (run > r_we_max_run) r_we_max_run = run;
        if (r_we_cyc < 0) begin r_we_cyc = cyc; r_we_div = o_div; end
      end else run = 0;
      if (o_clock_sel && !prev_sel && r_sel_rise_cyc < 0) r_sel_rise_cyc = cyc;
      if (!o_clock_sel) r_sel_low_seen = 1'b1;
      if (o_done) begin
        r_done_cnt++;
        if (r_done_cyc < 0) begin r_done_cyc = cyc; r_cur_div_sel = prev_cur; end
      end
      if (r_done_cyc >= 0 && o_req_ready) begin r_ready_cyc = cyc; break; end
      if (cyc >= max_cyc) begin r_timeout = 1'b1; break; end
      prev_sel = o_clock_sel;
      prev_cur = o_cur_div;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_req_ready); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_div !== 4'd6) begin n_fail++; $display("FAIL reset_div: got %0d expected 6", o_div); end
    n_checks++; if (o_cur_div !== 4'd6) begin n_fail++; $display("FAIL reset_cur_div: got %0d expected 6", o_cur_div); end
    n_checks++; if ({o_clock_sel, o_div_we, o_done, o_cur_en} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {o_clock_sel, o_div_we, o_done, o_cur_en}); end
  endtask

  // 6/0 -> 2/1: settle 64+4+2+4 = 74 cycles.
  task automatic test_main();
    run_seq(4'd2, 1'b1, 200);
    n_checks++; if (r_busy_at1 !== 1'b1 || r_ready_at1 !== 1'b0 || r_sel_at1 !== 1'b0) begin n_fail++; $display("FAIL main_bypass: busy/ready/sel got %b%b%b expected 100", r_busy_at1, r_ready_at1, r_sel_at1); end
    n_checks++; if (r_we_cyc !== 3) begin n_fail++; $display("FAIL main_we_cycle: got %0d expected 3", r_we_cyc); end
    n_checks++; if (r_we_div !== 4'd2) begin n_fail++; $display("FAIL main_we_div: got %0d expected 2", r_we_div); end
    n_checks++; if (r_we_cnt !== 1 || r_we_max_run !== 1) begin n_fail++; $display("FAIL main_we_pulse: count %0d run %0d expected 1 1", r_we_cnt, r_we_max_run); end
    n_checks++; if (r_sel_rise_cyc !== 78) begin n_fail++; $display("FAIL main_sel_rise: got %0d expected 78", r_sel_rise_cyc); end
    n_checks++; if (r_cur_div_sel !== 4'd2) begin n_fail++; $display("FAIL main_cur_div_select: got %0d expected 2", r_cur_div_sel); end
    n_checks++; if (r_done_cyc !== 79 || r_done_cnt !== 1) begin n_fail++; $display("FAIL main_done: cycle %0d count %0d expected 79 1", r_done_cyc, r_done_cnt); end
    n_checks++; if (r_ready_cyc !== 80) begin n_fail++; $display("FAIL main_ready: got %0d expected 80", r_ready_cyc); end
  endtask

  // 2/1 -> 2/1 is a no-op: done immediately, selector untouched.
  task automatic test_noop();
    run_seq(4'd2, 1'b1, 50);
    n_checks++; if (r_done_cyc !== 1) begin n_fail++; $display("FAIL noop_done: got %0d expected 1", r_done_cyc); end
    n_checks++; if (r_we_cnt !== 0) begin n_fail++; $display("FAIL noop_we: got %0d pulses expected 0", r_we_cnt); end
    n_checks++; if (r_sel_low_seen !== 1'b0) begin n_fail++; $display("FAIL noop_sel: got dropped expected held 1"); end
    n_checks++; if (r_ready_cyc !== 2) begin n_fail++; $display("FAIL noop_ready: got %0d expected 2", r_ready_cyc); end
  endtask

  // 2/1 -> 2/0: bypass then select, no write.
  task automatic test_en_off();
    run_seq(4'd2, 1'b0, 50);
    n_checks++; if (r_sel_at1 !== 1'b0) begin n_fail++; $display("FAIL enoff_sel_bypass: got %b expected 0", r_sel_at1); end
    n_checks++; if (r_we_cnt !== 0) begin n_fail++; $display("FAIL enoff_we: got %0d pulses expected 0", r_we_cnt); end
    n_checks++; if (r_done_cyc !== 4) begin n_fail++; $display("FAIL enoff_done: got %0d expected 4", r_done_cyc); end
    n_checks++; if (o_cur_en !== 1'b0 || o_clock_sel !== 1'b0) begin n_fail++; $display("FAIL enoff_final: cur_en %b sel %b expected 0 0", o_cur_en, o_clock_sel); end
  endtask

  // A = 2/1 (en-only, done at 4); B = 5/1 held valid, accepted at cycle 5,
  // write at 8, settle 4+32+6 = 42 cycles, done at 52, ready at 53.
  task automatic test_back_to_back();
    int cyc = 0;
    int done1 = -1, done2 = -1, acc = -1, we_c = -1, rdy2 = -1;
    logic [3:0] we_d = 'x;
    bit early_ready = 0;
    i_req_valid = 1'b1; i_req_div = 4'd2; i_req_en = 1'b1;
    while (cyc < 120) begin
      step();
      cyc++;
      if (cyc == 1) begin i_req_div = 4'd5; i_req_en = 1'b1; end
      if (acc >= 0 && cyc == acc + 1) i_req_valid = 1'b0;
      if (done1 < 0 && o_req_ready) early_ready = 1;
      if (o_done) begin if (done1 < 0) done1 = cyc; else if (done2 < 0) done2 = cyc; end
      if (o_div_we && we_c < 0) begin we_c = cyc; we_d = o_div; end
      if (acc < 0 && done1 >= 0 && o_req_ready && i_req_valid) acc = cyc;
      if (done2 >= 0 && o_req_ready) begin rdy2 = cyc; break; end
    end
    i_req_valid = 1'b0;
    n_checks++; if (early_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_while_busy: got ready high expected low"); end
    n_checks++; if (done1 !== 4) begin n_fail++; $display("FAIL b2b_done1: got %0d expected 4", done1); end
    n_checks++; if (acc !== 5) begin n_fail++; $display("FAIL b2b_accept: got %0d expected 5", acc); end
    n_checks++; if (we_c !== 8 || we_d !== 4'd5) begin n_fail++; $display("FAIL b2b_write: cycle %0d div %0d expected 8 5", we_c, we_d); end
    n_checks++; if (done2 !== 52) begin n_fail++; $display("FAIL b2b_done2: got %0d expected 52", done2); end
    n_checks++; if (rdy2 !== 53 || o_cur_div !== 4'd5) begin n_fail++; $display("FAIL b2b_final: ready %0d cur_div %0d expected 53 5", rdy2, o_cur_div); end
  endtask

  // 5/1 -> 14/1 (32+16384+6), then 14/1 -> 15/1 (16384+32768+6 = 49158).
  task automatic test_large_div();
    run_seq(4'd14, 1'b1, 60000);
    n_checks++; if (r_done_cyc !== 16427) begin n_fail++; $display("FAIL large14_done: got %0d expected 16427", r_done_cyc); end
    run_seq(4'd15, 1'b1, 60000);
    n_checks++; if (r_we_cyc !== 3 || r_we_div !== 4'd15) begin n_fail++; $display("FAIL large15_write: cycle %0d div %0d expected 3 15", r_we_cyc, r_we_div); end
    n_checks++; if (r_sel_low_seen !== 1'b1 || r_sel_rise_cyc !== 49162) begin n_fail++; $display("FAIL large15_sel_rise: got %0d expected 49162", r_sel_rise_cyc); end
    n_checks++; if (r_done_cyc !== 49163) begin n_fail++; $display("FAIL large15_done: got %0d expected 49163", r_done_cyc); end
    n_checks++; if (o_cur_div !== 4'd15 || o_cur_en !== 1'b1) begin n_fail++; $display("FAIL large15_cur: div %0d en %b expected 15 1", o_cur_div, o_cur_en); end
  endtask

  // Reset in the middle of SETTLE, then a fresh request from reset state.
  task automatic test_reset_mid_settle();
    bit done_seen = 0;
    i_req_valid = 1'b1; i_req_div = 4'd3; i_req_en = 1'b1;
    step();
    i_req_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_done) done_seen = 1;
    end
    n_checks++; if (o_busy !== 1'b1 || o_div !== 4'd3 || o_clock_sel !== 1'b0) begin n_fail++; $display("FAIL rst_pre_state: busy %b div %0d sel %b expected 1 3 0", o_busy, o_div, o_clock_sel); end
    rst = 1'b1;
    #1;
    n_checks++; if (o_div !== 4'd6 || o_cur_div !== 4'd6 || o_cur_en !== 1'b0 || o_req_ready !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_async: div %0d cur %0d en %b rdy %b busy %b expected 6 6 0 1 0", o_div, o_cur_div, o_cur_en, o_req_ready, o_busy); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (o_done) done_seen = 1;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (o_done) done_seen = 1;
    end
    n_checks++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got done pulse expected none"); end
    run_seq(4'd2, 1'b0, 200);
    n_checks++; if (r_done_cyc !== 79 || r_we_cyc !== 3) begin n_fail++; $display("FAIL rst_next_req: done %0d we %0d expected 79 3", r_done_cyc, r_we_cyc); end
    n_checks++; if (r_sel_low_seen !== 1'b1 || r_sel_rise_cyc !== -1 || o_cur_div !== 4'd2) begin n_fail++; $display("FAIL rst_next_sel: rise %0d cur %0d expected -1 2", r_sel_rise_cyc, o_cur_div); end
  endtask

  initial begin
    rst = 1'b1; i_req_valid = 1'b0; i_req_div = '0; i_req_en = 1'b0;
    #1;
    test_reset();
    repeat (3) step();
    rst = 1'b0;
    step();
    test_reset();
    test_main();
    test_noop();
    test_en_off();
    test_back_to_back();
    test_large_div();
    test_reset_mid_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_div_ctrl.md
Name: clock_div_ctrl

Overview:
- Sequencer that owns the configuration inputs of the core clock divider (div, div_we, clock_sel).
- Accepts reconfiguration requests from the system control register block over a valid/ready handshake.
- Applies each request glitch-safely: bypass select, divider write, settle wait for the new ratio, re-select.
- Tracks the divider's current configuration and reports busy/done to software.

Parameters:
DIV_LOG, 4, width of divider select; divide exponent range 0..2^DIV_LOG-1
SEL_WAIT, 2, cycles held in bypass before writing the divider (covers divider's clock_sel register stage)
SETTLE_MARGIN, 4, extra cycles added to the computed settle time
RST_DIV, 6, divider exponent after reset; equals the divider's own reset value

Ports:
i_clk  in  1  system clock, same clock as the divider
i_rst  in  1  asynchronous active-high reset
i_req_valid  in  1  reconfiguration request valid
i_req_div  in  DIV_LOG  requested divide exponent
i_req_en  in  1  1 = select divided clock, 0 = select i_clk (bypass)
o_req_ready  out  1  high only in IDLE; request accepted when valid & ready
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse when a request completes (including no-op requests)
o_div  out  DIV_LOG  to divider div input
o_div_we  out  1  to divider div_we, single-cycle pulse
o_clock_sel  out  1  to divider clock_sel
o_cur_div  out  DIV_LOG  currently applied exponent
o_cur_en  out  1  currently applied select

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - o_clock_sel = 0, o_div_we = 0, o_done = 0.
  - o_div = RST_DIV, o_cur_div = RST_DIV, o_cur_en = 0.
  - Counters = 0.
- Reset mid-sequence: the FSM aborts to reset values; the pending request is dropped and no o_done is issued.
- All outputs are registered. Stated values are those visible while the FSM is in the named state.
- FSM states: IDLE, BYPASS, WRITE, SETTLE, SELECT, DONE.
- IDLE:
  - On valid & ready, latch new_div = i_req_div and new_en = i_req_en.
  - If new_div == o_cur_div and new_en == o_cur_en, go to DONE (no-op). Otherwise go to BYPASS.
- BYPASS:
  - o_clock_sel = 0.
  - Hold exactly SEL_WAIT cycles.
  - Then go to WRITE if new_div != o_cur_div, else go to SELECT.
- WRITE (1 cycle):
  - o_div = new_div, o_div_we = 1.
  - Load settle counter with (1<<o_cur_div) + (1<<new_div) + 2 + SETTLE_MARGIN.
  - Counter width is 2^DIV_LOG+2 bits so the maximum value cannot overflow.
  - Go to SETTLE.
- SETTLE:
  - o_div_we = 0; decrement once per cycle.
  - Go to SELECT in the cycle after the count reaches 0.
  - SETTLE lasts exactly the loaded value in cycles.
- SELECT (1 cycle):
  - o_clock_sel = new_en.
  - o_cur_div <= new_div, o_cur_en <= new_en.
  - Go to DONE.
- DONE (1 cycle):
  - o_done = 1.
  - Return to IDLE; o_req_ready rises the next cycle.
- o_div holds its last written value in every state except WRITE.
- o_div_we is never high for more than one consecutive cycle.
- Requests presented while busy are not accepted; the requester holds valid (standard handshake).
- A request with new_en = 0 and a changed div still writes the divider and waits the settle time, then leaves o_clock_sel = 0.
- o_clock_sel never rises while the divider change is unsettled: it can only go 1 in SELECT.

Test Plan:
- Reset, then request div=2, en=1 at cycle 0 (SEL_WAIT=2, MARGIN=4):
  - BYPASS in cycles 1-2 with sel=0.
  - WRITE in cycle 3 with o_div_we=1, o_div=2.
  - SETTLE for 74 cycles (64+4+2+4), cycles 4-77.
  - SELECT in cycle 78 with sel=1 and cur_div=2.
  - o_done in cycle 79; ready in cycle 80.
- From cur_div=2, en=1, request div=2, en=1 -> o_done in cycle 1, no o_div_we pulse, o_clock_sel stays 1.
- From cur_div=2, en=1, request div=2, en=0 -> sel drops during BYPASS, then SELECT (no WRITE, no settle), done in cycle 4, cur_en=0.
- Request div=15 from div=15-1=14 -> settle count = 16384+32768+6 = 49158, no counter overflow, correct SELECT timing.
- Assert i_rst during SETTLE -> outputs go to reset values immediately, o_done never pulses, the next request is accepted from IDLE.
- Hold valid during busy with a second request (div=5) -> accepted only in the cycle after the first o_done; back-to-back sequences complete in order.
